// File: rtl/eqz_ctrl.sv
// eqz_ctrl: Moore controller for the repeated-addition multiplier.
// Optional flag-pair consistency check enabled by EQZ_PAIR_CHECK_EN.
module eqz_ctrl #(
  parameter int unsigned       CNT_W   = 16,
  parameter logic [CNT_W-1:0] TIMEOUT = CNT_W'(16'hFFFF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             eqz1,
  input  logic             neqz1,
  input  logic             eqz2,
  input  logic             neqz2,
  output logic             ldA,
  output logic             ldB,
  output logic             clrP,
  output logic             ldP,
  output logic             decB,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] iter
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_ADD,
    S_DONE,
    S_ERR
  } state_t;

  state_t         state;
  state_t         state_nx;
  logic [CNT_W:0] iter_inc;
  logic           pair_bad;
  logic           hit_limit;

  assign iter_inc  = {1'b0, iter} + (CNT_W+1)'(1);
  assign hit_limit = (iter_inc == {1'b0, TIMEOUT});

`ifdef EQZ_PAIR_CHECK_EN
  assign pair_bad = (eqz1 == neqz1) || (eqz2 == neqz2);
`else
  // The neqz flags carry no information when the pair is trusted.
  logic unused_neqz;
  assign unused_neqz = neqz1 ^ neqz2;
  assign pair_bad    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // iter saturates so a TIMEOUT at the top of the range cannot wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter <= '0;
    end else if (state == S_LOAD) begin
      iter <= '0;
    end else if (state == S_ADD && iter != TIMEOUT) begin
      iter <= iter_inc[CNT_W-1:0];
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (start) state_nx = S_LOAD;
      S_LOAD:  state_nx = S_CHECK;
      S_CHECK: begin
        if (pair_bad)          state_nx = S_ERR;
        else if (eqz1 || eqz2) state_nx = S_DONE;
        else                   state_nx = S_ADD;
      end
      S_ADD:   state_nx = hit_limit ? S_ERR : S_CHECK;
      S_DONE:  state_nx = S_IDLE;
      S_ERR:   if (start) state_nx = S_LOAD;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    ldA  = 1'b0;
    ldB  = 1'b0;
    clrP = 1'b0;
    ldP  = 1'b0;
    decB = 1'b0;
    busy = 1'b0;
    done = 1'b0;
    err  = 1'b0;
    unique case (state)
      S_LOAD: begin
        ldA  = 1'b1;
        ldB  = 1'b1;
        clrP = 1'b1;
        busy = 1'b1;
      end
      S_CHECK: busy = 1'b1;
      S_ADD: begin
        ldP  = 1'b1;
        decB = 1'b1;
        busy = 1'b1;
      end
      S_DONE:  done = 1'b1;
      S_ERR:   err  = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_eqz_ctrl.sv
// tb_eqz_ctrl: directed bench with a behavioural A/B/P datapath.
// Expectations follow EQZ_PAIR_CHECK_EN when the macro is defined.
module tb_eqz_ctrl;

  localparam logic [7:0] S_I = 8'b0000_0000;
  localparam logic [7:0] S_L = 8'b1110_0100;
  localparam logic [7:0] S_C = 8'b0000_0100;
  localparam logic [7:0] S_A = 8'b0001_1100;
  localparam logic [7:0] S_D = 8'b0000_0010;
  localparam logic [7:0] S_E = 8'b0000_0001;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        eqz1, neqz1, eqz2, neqz2;
  logic        ldA, ldB, clrP, ldP, decB;
  logic        busy, done, err;
  logic [15:0] iter;
  logic [7:0]  outs;

  logic [15:0] a_in = '0;
  logic [15:0] b_in = '0;
  logic [15:0] ra   = '0;
  logic [15:0] rb   = '0;
  logic [15:0] rp   = '0;
  logic        ovr2    = 1'b0;
  logic        o_eqz2  = 1'b0;
  logic        o_neqz2 = 1'b0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  eqz_ctrl #(
    .CNT_W  (16),
    .TIMEOUT(16'd4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .eqz1 (eqz1),
    .neqz1(neqz1),
    .eqz2 (eqz2),
    .neqz2(neqz2),
    .ldA  (ldA),
    .ldB  (ldB),
    .clrP (clrP),
    .ldP  (ldP),
    .decB (decB),
    .busy (busy),
    .done (done),
    .err  (err),
    .iter (iter)
  );

  assign outs  = {ldA, ldB, clrP, ldP, decB, busy, done, err};
  assign eqz1  = (ra == 16'd0);
  assign neqz1 = (ra != 16'd0);
  assign eqz2  = ovr2 ? o_eqz2  : (rb == 16'd0);
  assign neqz2 = ovr2 ? o_neqz2 : (rb != 16'd0);

  always @(posedge clk) begin
    if (ldA) ra <= a_in;
    if (ldB) rb <= b_in;
    else if (decB) rb <= rb - 16'd1;
    if (clrP) rp <= '0;
    else if (ldP) rp <= rp + ra;
  end

  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests++;
    if (outs !== S_I || iter !== 16'd0) begin
      fails++;
      $display("FAIL reset outs=%b iter=%0d exp 0/0", outs, iter);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_normal();
    logic [7:0] ex[$];
    ex = '{S_L, S_C, S_A, S_C, S_A, S_C, S_A, S_C, S_D, S_I};
    launch(16'd5, 16'd3);
    for (int k = 1; k <= ex.size(); k++) begin
      @(negedge clk);
      tests++;
      if (outs !== ex[k-1]) begin
        fails++;
        $display("FAIL normal cyc%0d outs=%b exp=%b", k, outs, ex[k-1]);
      end
    end
    tests++;
    if (iter !== 16'd3 || rp !== 16'd15) begin
      fails++;
      $display("FAIL normal_res iter=%0d P=%0d exp 3/15", iter, rp);
    end
  endtask

  task automatic test_zero(input logic [15:0] a, input logic [15:0] b);
    logic [7:0] ex[$];
    ex = '{S_L, S_C, S_D, S_I};
    launch(a, b);
    for (int k = 1; k <= ex.size(); k++) begin
      @(negedge clk);
      tests++;
      if (outs !== ex[k-1]) begin
        fails++;
        $display("FAIL zero cyc%0d outs=%b exp=%b", k, outs, ex[k-1]);
      end
    end
    tests++;
    if (iter !== 16'd0 || rp !== 16'd0) begin
      fails++;
      $display("FAIL zero_res iter=%0d P=%0d exp 0/0", iter, rp);
    end
  endtask

  task automatic test_pair(input logic val);
    logic [7:0] ex[$];
    logic [7:0] rx[$];
`ifdef EQZ_PAIR_CHECK_EN
    ex = '{S_L, S_C, S_A, S_C, S_E, S_E};
`else
    if (val) ex = '{S_L, S_C, S_A, S_C, S_D, S_I};
    else     ex = '{S_L, S_C, S_A, S_C, S_A, S_C, S_A, S_C, S_D, S_I};
`endif
    rx = '{S_L, S_C, S_A, S_C, S_A, S_C, S_A, S_C, S_D, S_I};
    launch(16'd5, 16'd3);
    for (int k = 1; k <= ex.size(); k++) begin
      @(negedge clk);
      tests++;
      if (outs !== ex[k-1]) begin
        fails++;
        $display("FAIL pair%0d cyc%0d outs=%b exp=%b", val, k, outs, ex[k-1]);
      end
      if (k == 4) begin
        ovr2    = 1'b1;
        o_eqz2  = val;
        o_neqz2 = val;
      end
      if (k == 5) ovr2 = 1'b0;
    end
`ifdef EQZ_PAIR_CHECK_EN
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= rx.size(); k++) begin
      @(negedge clk);
      tests++;
      if (outs !== rx[k-1]) begin
        fails++;
        $display("FAIL pair_rs cyc%0d outs=%b exp=%b", k, outs, rx[k-1]);
      end
    end
`endif
  endtask

  task automatic test_timeout();
    logic [7:0] ex[$];
    logic [7:0] rx[$];
    ex = '{S_L, S_C, S_A, S_C, S_A, S_C, S_A, S_C, S_A, S_E, S_E};
    rx = '{S_L, S_C, S_D, S_I};
    launch(16'd5, 16'd9);
    for (int k = 1; k <= ex.size(); k++) begin
      @(negedge clk);
      tests++;
      if (outs !== ex[k-1]) begin
        fails++;
        $display("FAIL timeout cyc%0d outs=%b exp=%b", k, outs, ex[k-1]);
      end
    end
    tests++;
    if (iter !== 16'd4) begin
      fails++;
      $display("FAIL timeout_iter iter=%0d exp 4", iter);
    end
    launch(16'd5, 16'd0);
    for (int k = 1; k <= rx.size(); k++) begin
      @(negedge clk);
      tests++;
      if (outs !== rx[k-1]) begin
        fails++;
        $display("FAIL err_restart cyc%0d outs=%b exp=%b", k, outs, rx[k-1]);
      end
    end
  endtask

  task automatic test_reset_mid();
    launch(16'd5, 16'd3);
    repeat (5) @(negedge clk);
    tests++;
    if (outs !== S_A || iter !== 16'd1) begin
      fails++;
      $display("FAIL mid_pre outs=%b iter=%0d exp %b/1", outs, iter, S_A);
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (outs !== S_I || iter !== 16'd0) begin
      fails++;
      $display("FAIL mid_async outs=%b iter=%0d exp 0/0", outs, iter);
    end
    @(posedge clk);
    #1;
    tests++;
    if (outs !== S_I) begin
      fails++;
      $display("FAIL mid_hold outs=%b exp 0", outs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    test_zero(16'd7, 16'd0);
  endtask

  task automatic test_busy_restart();
    logic [7:0] ex[$];
    ex = '{S_L, S_C, S_A, S_C, S_A, S_C, S_A, S_C, S_D, S_I, S_I};
    launch(16'd5, 16'd3);
    for (int k = 1; k <= ex.size(); k++) begin
      @(negedge clk);
      tests++;
      if (outs !== ex[k-1]) begin
        fails++;
        $display("FAIL busy cyc%0d outs=%b exp=%b", k, outs, ex[k-1]);
      end
      if (k == 2) start = 1'b1;
      if (k == 7) start = 1'b0;
    end
    tests++;
    if (iter !== 16'd3 || rp !== 16'd15) begin
      fails++;
      $display("FAIL busy_res iter=%0d P=%0d exp 3/15", iter, rp);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_normal();
    test_zero(16'd5, 16'd0);
    test_zero(16'd0, 16'd4);
    test_pair(1'b1);
    test_pair(1'b0);
    test_timeout();
    test_reset_mid();
    test_busy_restart();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
